cacheline_adapter: RTL and testbench

- Memory-side responder for the cache's downward-facing port (dfp).
- Accepts one 256-bit line read or write request from the cache miss/writeback logic.
- Converts it into a 4-beat, 64-bit burst transaction on the banked memory (bmem) interface.
- Returns a single-cycle dfp_resp, plus assembled dfp_rdata for reads.
- Sits between the data/instruction cache and the memory model/arbiter.

---
 rtl/cacheline_adapter.sv | 117 +++++++++++
 tb/tb_cacheline_adapter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
// Line-to-burst adapter: turns one 256-bit dfp line request into a 4-beat 64-bit bmem burst.
// Optional macro CACHELINE_ADAPTER_RADDR_CHECK_EN: drop read beats whose bmem_raddr differs from the line address.
module cacheline_adapter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;

  state_t                       state, next_state;
  logic [CNT_W-1:0]             cnt;
  logic [ADDR_W-1:0]            line_addr;
  logic [BEATS-1:0][BEAT_W-1:0] wline;
  logic [BEATS-1:0][BEAT_W-1:0] rline;
  logic [ADDR_W-1:0]            req_addr;
  logic                         accept_wr, accept_rd, wr_beat, rd_beat;
  logic                         last_beat, rvalid_ok, unused_ok;

  assign req_addr  = {dfp_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign dfp_rdata = rline;

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  assign rvalid_ok = bmem_rvalid && (bmem_raddr == line_addr);
  assign unused_ok = ^dfp_addr[OFF_W-1:0];
`else
  assign rvalid_ok = bmem_rvalid;
  assign unused_ok = ^{bmem_raddr, dfp_addr[OFF_W-1:0]};
`endif

  // Requests are only looked at in IDLE; a write wins so a dirty victim leaves before the refill.
  always_comb begin
    next_state = state;
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    wr_beat    = 1'b0;
    rd_beat    = 1'b0;
    dfp_resp   = 1'b0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (bmem_ready && !rst) begin
          if (dfp_write) begin
            accept_wr  = 1'b1;
            next_state = WRITE;
          end else if (dfp_read) begin
            accept_rd  = 1'b1;
            bmem_read  = 1'b1;
            bmem_addr  = req_addr;
            next_state = READ_WAIT;
          end
        end
      end
      WRITE: begin
        bmem_write = 1'b1;
        bmem_addr  = line_addr;
        bmem_wdata = wline[cnt];
        if (bmem_ready) begin
          wr_beat = 1'b1;
          if (last_beat) next_state = RESP;
        end
      end
      READ_WAIT: begin
        rd_beat = rvalid_ok;
        if (rvalid_ok && last_beat) next_state = RESP;
      end
      RESP: begin
        dfp_resp   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      line_addr <= '0;
      wline     <= '0;
      rline     <= '0;
    end else begin
      state <= next_state;
      if (accept_wr || accept_rd) line_addr <= req_addr;
      if (accept_wr) wline <= dfp_wdata;
      // The beat counter wraps back to 0 on its own after the last beat.
      if (wr_beat || rd_beat) cnt <= cnt + CNT_W'(1);
      if (rd_beat) rline[cnt] <= bmem_rdata;
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter: reads, writes, stalls, dirty-miss ordering, reset, raddr filter.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read, dfp_write;
  logic [255:0] dfp_wdata, dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int checks   = 0;
  int failures = 0;
  int beats;

  logic [63:0] wexp [7];
  logic        rdy  [7];
  logic [63:0] rbeat [4];

  cacheline_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then return at the falling edge to sample.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic ready, input logic rv, input logic [31:0] ra,
                               input logic [63:0] rdat);
    @(posedge clk);
    #1;
    dfp_read    = rd;
    dfp_write   = wr;
    dfp_addr    = addr;
    bmem_ready  = ready;
    bmem_rvalid = rv;
    bmem_raddr  = ra;
    bmem_rdata  = rdat;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_resp",   dfp_resp,   0);
    checkOutput("reset_bread",  bmem_read,  0);
    checkOutput("reset_bwrite", bmem_write, 0);
    checkOutput("reset_baddr",  bmem_addr,  0);
    checkOutput("reset_bwdata", bmem_wdata, 0);
    checkOutput("reset_rdata",  dfp_rdata,  0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Read with a two-cycle gap after the first beat
    applyStimulus(1, 0, 32'h0000_1234, 1, 0, 0, 0);
    checkOutput("t1_bread",  bmem_read, 1);
    checkOutput("t1_baddr",  bmem_addr, 32'h0000_1220);
    checkOutput("t1_bwrite", bmem_write, 0);
    applyStimulus(1, 0, 32'h0000_1234, 1, 1, 32'h0000_1220, 64'h1111_1111_1111_1111);
    checkOutput("t1_bread_once", bmem_read, 0);
    applyStimulus(1, 0, 32'h0000_1234, 1, 0, 0, 0);
    applyStimulus(1, 0, 32'h0000_1234, 1, 0, 0, 0);
    checkOutput("t1_gap_resp", dfp_resp, 0);
    applyStimulus(1, 0, 32'h0000_1234, 1, 1, 32'h0000_1220, 64'h2222_2222_2222_2222);
    applyStimulus(1, 0, 32'h0000_1234, 1, 1, 32'h0000_1220, 64'h3333_3333_3333_3333);
    applyStimulus(1, 0, 32'h0000_1234, 1, 1, 32'h0000_1220, 64'h4444_4444_4444_4444);
    checkOutput("t1_resp_early", dfp_resp, 0);
    applyStimulus(1, 0, 32'h0000_1234, 1, 0, 0, 0);
    checkOutput("t1_resp", dfp_resp, 1);
    checkOutput("t1_rdata", dfp_rdata,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("t1_resp_once", dfp_resp, 0);
    checkOutput("t1_rdata_held", dfp_rdata,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Write with bmem_ready stuck high: beats in cycles 1-4, response in cycle 5
    dfp_wdata = {64'h0000_0000_0000_000D, 64'h0000_0000_0000_000C,
                 64'h0000_0000_0000_000B, 64'h0000_0000_0000_000A};
    applyStimulus(0, 1, 32'h0000_5678, 1, 0, 0, 0);
    checkOutput("t2_accept_bwrite", bmem_write, 0);
    checkOutput("t2_accept_bread",  bmem_read, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 32'h0000_5678, 1, 0, 0, 0);
      checkOutput("t2_bwrite", bmem_write, 1);
      checkOutput("t2_baddr",  bmem_addr, 32'h0000_5660);
      checkOutput("t2_bwdata", bmem_wdata, 64'(10 + i));
      checkOutput("t2_resp_early", dfp_resp, 0);
    end
    applyStimulus(0, 1, 32'h0000_5678, 1, 0, 0, 0);
    checkOutput("t2_resp", dfp_resp, 1);
    checkOutput("t2_bwrite_done", bmem_write, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("t2_resp_once", dfp_resp, 0);

    // Write stalled for three cycles on beat B
    dfp_wdata = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    rdy  = '{1, 0, 0, 0, 1, 1, 1};
    wexp = '{64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002, 64'hBBBB_0000_0000_0002,
             64'hBBBB_0000_0000_0002, 64'hBBBB_0000_0000_0002, 64'hCCCC_0000_0000_0003,
             64'hDDDD_0000_0000_0004};
    beats = 0;
    applyStimulus(0, 1, 32'h0000_0040, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 1, 32'h0000_0040, rdy[i], 0, 0, 0);
      checkOutput("t3_bwdata", bmem_wdata, wexp[i]);
      checkOutput("t3_resp_early", dfp_resp, 0);
      if (bmem_write && bmem_ready) beats++;
    end
    checkOutput("t3_beats", 256'(beats), 4);
    applyStimulus(0, 1, 32'h0000_0040, 1, 0, 0, 0);
    checkOutput("t3_resp", dfp_resp, 1);
    checkOutput("t3_bwrite_done", bmem_write, 0);

    // Dirty miss: both requests high, write burst goes first, then the read
    dfp_wdata = {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
                 64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001};
    applyStimulus(1, 1, 32'h0000_2000, 1, 0, 0, 0);
    checkOutput("t4_no_bread", bmem_read, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 32'h0000_2000, 1, 0, 0, 0);
      checkOutput("t4_bwrite", bmem_write, 1);
      checkOutput("t4_bread_excl", bmem_read, 0);
      checkOutput("t4_baddr", bmem_addr, 32'h0000_2000);
      checkOutput("t4_bwdata", bmem_wdata, {32'h5555_0000, 32'(i + 1)});
    end
    applyStimulus(1, 1, 32'h0000_2000, 1, 0, 0, 0);
    checkOutput("t4_wr_resp", dfp_resp, 1);
    applyStimulus(1, 0, 32'h0000_4000, 1, 0, 0, 0);
    checkOutput("t4_bread", bmem_read, 1);
    checkOutput("t4_rd_baddr", bmem_addr, 32'h0000_4000);
    checkOutput("t4_resp_gap", dfp_resp, 0);
    rbeat = '{64'h6666_0000_0000_0000, 64'h6666_0000_0000_0001,
              64'h6666_0000_0000_0002, 64'h6666_0000_0000_0003};
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 32'h0000_4000, 1, 1, 32'h0000_4000, rbeat[i]);
    applyStimulus(1, 0, 32'h0000_4000, 1, 0, 0, 0);
    checkOutput("t4_rd_resp", dfp_resp, 1);
    checkOutput("t4_rdata", dfp_rdata, {rbeat[3], rbeat[2], rbeat[1], rbeat[0]});
    applyStimulus(0, 0, 0, 1, 0, 0, 0);

    // Reset after two read beats abandons the burst
    applyStimulus(1, 0, 32'h0000_8000, 1, 0, 0, 0);
    checkOutput("t5_bread", bmem_read, 1);
    applyStimulus(1, 0, 32'h0000_8000, 1, 1, 32'h0000_8000, 64'h7777_0000_0000_0001);
    applyStimulus(1, 0, 32'h0000_8000, 1, 1, 32'h0000_8000, 64'h7777_0000_0000_0002);
    @(posedge clk);
    #1;
    rst = 1'b1; dfp_read = 1'b0; bmem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; bmem_rvalid = 1'b1; bmem_rdata = 64'h7777_0000_0000_0003;
    @(negedge clk);
    checkOutput("t5_resp",   dfp_resp,   0);
    checkOutput("t5_bread0", bmem_read,  0);
    checkOutput("t5_bwrite", bmem_write, 0);
    checkOutput("t5_baddr",  bmem_addr,  0);
    checkOutput("t5_bwdata", bmem_wdata, 0);
    checkOutput("t5_rdata",  dfp_rdata,  0);
    applyStimulus(0, 0, 0, 1, 1, 32'h0000_8000, 64'h7777_0000_0000_0004);
    checkOutput("t5_late_resp", dfp_resp, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t5_no_resp", dfp_resp, 0);
      checkOutput("t5_rdata_clear", dfp_rdata, 0);
    end

    // A stray beat tagged with a foreign address precedes the real ones
    rbeat = '{64'h8888_0000_0000_0000, 64'h8888_0000_0000_0001,
              64'h8888_0000_0000_0002, 64'h8888_0000_0000_0003};
    applyStimulus(1, 0, 32'h0000_3000, 1, 0, 0, 0);
    checkOutput("t6_bread", bmem_read, 1);
    applyStimulus(1, 0, 32'h0000_3000, 1, 1, 32'h9999_0000, 64'hBAD0_BAD0_BAD0_BAD0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 32'h0000_3000, 1, 1, 32'h0000_3000, rbeat[i]);
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    checkOutput("t6_resp_early", dfp_resp, 0);
    applyStimulus(1, 0, 32'h0000_3000, 1, 0, 0, 0);
    checkOutput("t6_resp", dfp_resp, 1);
    checkOutput("t6_rdata", dfp_rdata, {rbeat[3], rbeat[2], rbeat[1], rbeat[0]});
`else
    checkOutput("t6_resp", dfp_resp, 1);
    checkOutput("t6_rdata", dfp_rdata, {rbeat[2], rbeat[1], rbeat[0], 64'hBAD0_BAD0_BAD0_BAD0});
    applyStimulus(1, 0, 32'h0000_3000, 1, 0, 0, 0);
    checkOutput("t6_resp_once", dfp_resp, 0);
`endif
    applyStimulus(0, 0, 0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
